// File: rtl/serial_in_left_register16.sv
// Serial-to-parallel receiver: collects an MSB-first bit stream into MSB-wide words
// and presents each completed word on a registered valid/ready output port.
module serial_in_left_register16 #(
  parameter int MSB = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_sin,
  input  logic                   i_sin_valid,
  input  logic                   i_clear,
  output logic [MSB-1:0]         o_dout,
  output logic                   o_dout_valid,
  input  logic                   i_dout_ready,
  output logic [$clog2(MSB)-1:0] o_bit_cnt,
  output logic                   o_overrun
);

  localparam int CW = $clog2(MSB);
  localparam logic [CW-1:0] LAST_BIT = CW'(MSB - 1);

  logic [MSB-1:0] shreg_q, shreg_d;
  logic [MSB-1:0] dout_q, dout_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           overrun_q, overrun_d;
  logic [MSB-1:0] word;

  assign word = {shreg_q[MSB-2:0], i_sin};

  always_comb begin
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // The handshake is independent of clear; a completion below may re-raise valid.
    if (valid_q && i_dout_ready) valid_d = 1'b0;

    if (i_clear) begin
      shreg_d   = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (i_sin_valid) begin
      shreg_d = word;
      if (cnt_q == LAST_BIT) begin
        cnt_d = '0;
        if (!valid_q || i_dout_ready) begin
          dout_d  = word;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shreg_q   <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_dout       = dout_q;
  assign o_dout_valid = valid_q;
  assign o_bit_cnt    = cnt_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_serial_in_left_register16.sv
// Directed bench for serial_in_left_register16: word assembly, gaps, overrun,
// back-to-back acceptance, clear abort and mid-word reset.
module tb_serial_in_left_register16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_sin = 1'b0;
  logic        i_sin_valid = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_dout_ready = 1'b0;
  logic [15:0] o_dout;
  logic        o_dout_valid;
  logic [3:0]  o_bit_cnt;
  logic        o_overrun;

  int checks = 0;
  int errors = 0;

  serial_in_left_register16 #(.MSB(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_sin        (i_sin),
    .i_sin_valid  (i_sin_valid),
    .i_clear      (i_clear),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (i_dout_ready),
    .o_bit_cnt    (o_bit_cnt),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change #1 after a rising edge, so outputs are read well away from it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    i_sin = b;
    i_sin_valid = 1'b1;
    tick();
    i_sin_valid = 1'b0;
    i_sin = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) send_bit(w[i]);
  endtask

  task automatic consume();
    i_dout_ready = 1'b1;
    tick();
    i_dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    checks++;
    if (o_dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h want 0000", o_dout); end
    checks++;
    if (o_dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_dout_valid); end
    checks++;
    if (o_bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", o_bit_cnt); end
    checks++;
    if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", o_overrun); end
  endtask

  task automatic test_basic();
    send_bits(16'hA5C3, 15);
    checks++;
    if (o_bit_cnt !== 4'd15 || o_dout_valid !== 1'b0) begin
      errors++; $display("FAIL basic_15bits cnt %0d valid %b want 15 0", o_bit_cnt, o_dout_valid);
    end
    send_bit(1'b1);
    checks++;
    if (o_dout !== 16'hA5C3) begin errors++; $display("FAIL basic_dout got %h want a5c3", o_dout); end
    checks++;
    if (o_dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", o_dout_valid); end
    checks++;
    if (o_bit_cnt !== 4'd0) begin errors++; $display("FAIL basic_cnt_wrap got %0d want 0", o_bit_cnt); end
    tick();
    checks++;
    if (o_dout_valid !== 1'b1) begin errors++; $display("FAIL basic_hold_valid got %b want 1", o_dout_valid); end
    consume();
    checks++;
    if (o_dout_valid !== 1'b0 || o_dout !== 16'hA5C3) begin
      errors++; $display("FAIL basic_take valid %b dout %h want 0 a5c3", o_dout_valid, o_dout);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] w = 16'h8001;
    for (int i = 15; i >= 0; i--) begin
      send_bit(w[i]);
      if (i > 0) begin
        tick();
        checks++;
        if (o_bit_cnt !== 4'(16 - i) || o_dout_valid !== 1'b0) begin
          errors++; $display("FAIL gap_hold bit %0d cnt %0d valid %b want %0d 0", i, o_bit_cnt, o_dout_valid, 16 - i);
        end
      end
    end
    checks++;
    if (o_dout !== 16'h8001 || o_dout_valid !== 1'b1 || o_bit_cnt !== 4'd0) begin
      errors++; $display("FAIL gap_word dout %h valid %b cnt %0d want 8001 1 0", o_dout, o_dout_valid, o_bit_cnt);
    end
    consume();
  endtask

  task automatic test_overrun();
    send_bits(16'h1234, 16);
    checks++;
    if (o_dout !== 16'h1234 || o_dout_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_first dout %h valid %b want 1234 1", o_dout, o_dout_valid);
    end
    send_bits(16'hFFFF, 15);
    checks++;
    if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", o_overrun); end
    send_bit(1'b1);
    checks++;
    if (o_overrun !== 1'b1 || o_dout !== 16'h1234 || o_dout_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_drop ovr %b dout %h valid %b want 1 1234 1", o_overrun, o_dout, o_dout_valid);
    end
    tick();
    checks++;
    if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", o_overrun); end
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    checks++;
    if (o_overrun !== 1'b0 || o_dout !== 16'h1234 || o_dout_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_clear ovr %b dout %h valid %b want 0 1234 1", o_overrun, o_dout, o_dout_valid);
    end
    // Handshake still proceeds while clear is asserted.
    i_clear = 1'b1;
    i_dout_ready = 1'b1;
    tick();
    i_clear = 1'b0;
    i_dout_ready = 1'b0;
    checks++;
    if (o_dout_valid !== 1'b0 || o_dout !== 16'h1234) begin
      errors++; $display("FAIL clear_handshake valid %b dout %h want 0 1234", o_dout_valid, o_dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w = 16'hF00F;
    send_bits(16'h00FF, 16);
    send_bits(w, 15);
    i_dout_ready = 1'b1;
    send_bit(w[0]);
    i_dout_ready = 1'b0;
    checks++;
    if (o_dout !== 16'hF00F || o_dout_valid !== 1'b1 || o_overrun !== 1'b0) begin
      errors++; $display("FAIL b2b dout %h valid %b ovr %b want f00f 1 0", o_dout, o_dout_valid, o_overrun);
    end
    consume();
  endtask

  task automatic test_clear_abort();
    send_bits(16'hFFFF, 7);
    i_clear = 1'b1;
    send_bit(1'b1);
    i_clear = 1'b0;
    checks++;
    if (o_bit_cnt !== 4'd0 || o_dout_valid !== 1'b0) begin
      errors++; $display("FAIL abort_cnt cnt %0d valid %b want 0 0", o_bit_cnt, o_dout_valid);
    end
    send_bits(16'h5A5A, 15);
    checks++;
    if (o_dout_valid !== 1'b0) begin errors++; $display("FAIL abort_early got %b want 0", o_dout_valid); end
    send_bit(1'b0);
    checks++;
    if (o_dout !== 16'h5A5A || o_dout_valid !== 1'b1) begin
      errors++; $display("FAIL abort_word dout %h valid %b want 5a5a 1", o_dout, o_dout_valid);
    end
  endtask

  task automatic test_reset_mid();
    send_bits(16'hFFFF, 9);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    checks++;
    if (o_dout !== 16'h0 || o_dout_valid !== 1'b0 || o_bit_cnt !== 4'd0 || o_overrun !== 1'b0) begin
      errors++; $display("FAIL mid_reset dout %h valid %b cnt %0d ovr %b want 0 0 0 0", o_dout, o_dout_valid, o_bit_cnt, o_overrun);
    end
    send_bits(16'h0F0F, 15);
    checks++;
    if (o_dout_valid !== 1'b0) begin errors++; $display("FAIL mid_early got %b want 0", o_dout_valid); end
    send_bit(1'b1);
    checks++;
    if (o_dout !== 16'h0F0F || o_dout_valid !== 1'b1 || o_bit_cnt !== 4'd0) begin
      errors++; $display("FAIL mid_word dout %h valid %b cnt %0d want 0f0f 1 0", o_dout, o_dout_valid, o_bit_cnt);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_clear_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
